// File: rtl/down_counter_tc.sv
// down_counter_tc: loadable down counter with one-clock tc pulse, one-shot or auto-reload, falling-edge clocked.
// Optional sticky irq/irq_clr ports are enabled by defining DOWN_COUNTER_TC_IRQ_EN.
module down_counter_tc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
`ifdef DOWN_COUNTER_TC_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);
    logic [WIDTH-1:0] q_q, q_d, reload_q, reload_d;
    logic             busy_q, busy_d, tc_q, tc_d, step, term;
    always_comb begin
        step     = !load && en && busy_q;
        term     = step && q_q == WIDTH'(1);
        q_d      = load ? load_val : !step ? q_q : !term ? q_q - WIDTH'(1) : mode ? reload_q : '0;
        reload_d = load ? load_val : reload_q;
        busy_d   = load ? |load_val : (term && !mode) ? 1'b0 : busy_q;
        tc_d     = term;
    end
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_q      <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
        end
    end
    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = busy_q;
`ifdef DOWN_COUNTER_TC_IRQ_EN
    logic irq_q, irq_d;
    // a new terminal event beats a simultaneous clear
    assign irq_d = tc_d || (irq_q && !irq_clr);
    always_ff @(negedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_down_counter_tc.sv
// tb_down_counter_tc: directed scenarios plus randomized run against a behavioural model of the down counter.
module tb_down_counter_tc;
    localparam int W = 4;
    logic clk = 1'b0, reset = 1'b1, load = 1'b0, en = 1'b0, mode = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic tc, busy;
    int checks = 0, passed = 0;
    int m_q = 0, m_rl = 0;
    bit m_busy = 0, m_tc = 0, m_irq = 0;
`ifdef DOWN_COUNTER_TC_IRQ_EN
    logic irq, irq_clr = 1'b0;
`endif

    down_counter_tc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en), .mode(mode),
        .q(q), .tc(tc), .busy(busy)
`ifdef DOWN_COUNTER_TC_IRQ_EN
        , .irq(irq), .irq_clr(irq_clr)
`endif
    );

    always #5 clk = ~clk;

    // advance one falling edge, update the model from the inputs seen at that edge, sample 1ns later
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            m_q = 0; m_rl = 0; m_busy = 0; m_tc = 0; m_irq = 0;
        end else begin
            if (load) begin
                m_q = int'(load_val); m_rl = int'(load_val); m_busy = (load_val != 0); m_tc = 0;
            end else if (en && m_busy) begin
                if (m_q > 1) begin
                    m_q = m_q - 1; m_tc = 0;
                end else begin
                    m_tc = 1;
                    if (mode) m_q = m_rl;
                    else begin m_q = 0; m_busy = 0; end
                end
            end else m_tc = 0;
`ifdef DOWN_COUNTER_TC_IRQ_EN
            m_irq = m_tc || (m_irq && !irq_clr);
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; load = 1; load_val = 4'd9; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({q, tc, busy} !== {4'd0, 1'b0, 1'b0})
                $display("FAIL reset_hold: q=%0d tc=%0b busy=%0b, want 0 0 0", q, tc, busy);
            else passed++;
        end
        load = 0; en = 0;
        #2 reset = 0;
        tick();
        checks++;
        if ({q, tc, busy} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_release: q=%0d tc=%0b busy=%0b, want 0 0 0", q, tc, busy);
        else passed++;
    endtask

    task automatic test_oneshot();
        logic [3:0] eq [10] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic       et [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic       eb [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        load = 1; load_val = 4'd5; mode = 0; en = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            load = 0;
            checks++;
            if ({q, tc, busy} !== {eq[i], et[i], eb[i]})
                $display("FAIL oneshot[%0d]: q=%0d tc=%0b busy=%0b, want %0d %0b %0b", i, q, tc, busy, eq[i], et[i], eb[i]);
            else passed++;
        end
    endtask

    task automatic test_auto_reload();
        logic [3:0] eq [10] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        logic       et [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        int pulses = 0;
        load = 1; load_val = 4'd3; mode = 1; en = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            load = 0;
            pulses += int'(tc);
            checks++;
            if ({q, tc, busy} !== {eq[i], et[i], 1'b1})
                $display("FAIL auto[%0d]: q=%0d tc=%0b busy=%0b, want %0d %0b 1", i, q, tc, busy, eq[i], et[i]);
            else passed++;
        end
        checks++;
        if (pulses !== 3) $display("FAIL auto_pulses: got %0d, want 3", pulses);
        else passed++;
        mode = 0;
    endtask

    task automatic test_reload_mid();
        logic [3:0] eq [6] = '{4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
        logic       et [6] = '{0, 0, 0, 0, 0, 1};
        load = 1; load_val = 4'd6; mode = 0; en = 1;
        for (int i = 0; i < 6; i++) begin
            load = (i == 0 || i == 3);
            load_val = (i == 0) ? 4'd6 : 4'd2;
            tick();
            checks++;
            if ({q, tc} !== {eq[i], et[i]})
                $display("FAIL reload_mid[%0d]: q=%0d tc=%0b, want %0d %0b", i, q, tc, eq[i], et[i]);
            else passed++;
        end
        load = 0;
    endtask

    task automatic test_enable_async_reset();
        logic [3:0] eq [4] = '{4'd7, 4'd7, 4'd7, 4'd6};
        logic       ee [4] = '{1, 0, 0, 1};
        load = 1; load_val = 4'd8; mode = 0; en = 0;
        tick();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            en = ee[i];
            tick();
            checks++;
            if (q !== eq[i]) $display("FAIL enable[%0d]: q=%0d, want %0d", i, q, eq[i]);
            else passed++;
        end
        #2 reset = 1;
        #1;
        checks++;
        if ({q, busy} !== {4'd0, 1'b0}) $display("FAIL async_reset: q=%0d busy=%0b, want 0 0", q, busy);
        else passed++;
        m_q = 0; m_rl = 0; m_busy = 0; m_tc = 0; m_irq = 0;
        tick();
        reset = 0; en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 3) != 0);
            mode = ($urandom_range(0, 5) != 0);
`ifdef DOWN_COUNTER_TC_IRQ_EN
            irq_clr = ($urandom_range(0, 3) == 0);
`endif
            tick();
            checks++;
            if ({q, tc, busy} !== {m_q[W-1:0], m_tc, m_busy})
                $display("FAIL random[%0d]: q=%0d tc=%0b busy=%0b, want %0d %0b %0b", i, q, tc, busy, m_q, m_tc, m_busy);
            else passed++;
`ifdef DOWN_COUNTER_TC_IRQ_EN
            checks++;
            if (irq !== m_irq) $display("FAIL random_irq[%0d]: irq=%0b, want %0b", i, irq, m_irq);
            else passed++;
`endif
        end
        reset = 0; load = 0; en = 0;
`ifdef DOWN_COUNTER_TC_IRQ_EN
        irq_clr = 0;
`endif
    endtask

`ifdef DOWN_COUNTER_TC_IRQ_EN
    task automatic test_irq();
        logic ei [4] = '{0, 0, 1, 1};
        irq_clr = 1; load = 0; en = 0;
        tick();
        irq_clr = 0; load = 1; load_val = 4'd2; mode = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 0;
            checks++;
            if (irq !== ei[i]) $display("FAIL irq_oneshot[%0d]: irq=%0b, want %0b", i, irq, ei[i]);
            else passed++;
        end
        irq_clr = 1;
        tick();
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear: irq=%0b, want 0", irq);
        else passed++;
        load = 1; load_val = 4'd1; mode = 1;
        tick();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({irq, tc, q} !== {1'b1, 1'b1, 4'd1})
                $display("FAIL irq_setwins[%0d]: irq=%0b tc=%0b q=%0d, want 1 1 1", i, irq, tc, q);
            else passed++;
        end
        irq_clr = 0; en = 0; mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_reload_mid();
        test_enable_async_reset();
`ifdef DOWN_COUNTER_TC_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
